sd_frame_ctrl: RTL and testbench

//  Frame-level controller wrapped around a programmable overlapping Mealy sequence detector.

---
 rtl/sd_frame_ctrl.sv | 115 +++++++++++
 tb/tb_sd_frame_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sd_frame_ctrl.sv
// Frame controller around a programmable overlapping Mealy sequence detector.
// Optional one-hot state LEDs are enabled with the SD_LED_EN macro.
module sd_frame_ctrl #(
  parameter int W    = 8,
  parameter int PMAX = 4,
  parameter int LW   = 3,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [PMAX-1:0] cfg_pat,
  input  logic [LW-1:0]   cfg_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            sd_din,
  output logic            dout,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   hit_cnt,
`ifdef SD_LED_EN
  output logic [2:0]      led,
`endif
  output logic [1:0]      dbg_state
);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and the source must hold the word until then.

  localparam int IW = $clog2(W);
  localparam logic [LW-1:0]   LMAX = LW'(PMAX);
  localparam logic [LW-1:0]   LDEF = (PMAX < 3) ? LW'(PMAX) : LW'(3);
  localparam logic [PMAX-1:0] PDEF = PMAX'(7);
  localparam logic [CW-1:0]   CMAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, REPORT = 2'd2} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    data_q;
  logic [IW-1:0]   idx;
  logic [PMAX-1:0] hist, pat, mask;
  logic [LW-1:0]   len, seen, len_clamped;
  logic [PMAX:0]   window;
  logic            accept;

  assign accept      = in_valid && in_ready;
  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign done        = (state == REPORT);
  assign dbg_state   = state;
  assign sd_din      = (state == SHIFT) ? data_q[idx] : 1'b0;
  assign window      = {hist, sd_din};
  assign len_clamped = (cfg_len > LMAX) ? LMAX : cfg_len;

`ifdef SD_LED_EN
  assign led = {state == REPORT, state == SHIFT, state == IDLE};
`endif

  // Only the newest len bits of the window take part in the compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PMAX; i++) mask[i] = (i < int'(len));
  end

  assign dout = (state == SHIFT) && (len != '0) &&
                (((window[PMAX-1:0] ^ pat) & mask) == '0) &&
                (seen >= len - LW'(1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (idx == '0) state_nx = REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      data_q  <= '0;
      idx     <= '0;
      hist    <= '0;
      seen    <= '0;
      hit_cnt <= '0;
      pat     <= PDEF;
      len     <= LDEF;
    end else begin
      state <= state_nx;
      if (cfg_we && state == IDLE) begin
        pat <= cfg_pat;
        len <= len_clamped;
      end
      case (state)
        IDLE: if (accept) begin
          data_q  <= in_data;
          idx     <= IW'(W - 1);
          hist    <= '0;
          seen    <= '0;
          hit_cnt <= '0;
        end
        SHIFT: begin
          hist <= window[PMAX-1:0];
          if (seen != LMAX) seen <= seen + LW'(1);
          if (dout && hit_cnt != CMAX) hit_cnt <= hit_cnt + CW'(1);
          if (idx != '0) idx <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_frame_ctrl.sv
// Directed bench for sd_frame_ctrl: per-bit dout model plus a hit-count scoreboard.
// A second instance with CW=2 covers counter saturation.
module tb_sd_frame_ctrl;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we, in_valid, in_ready, sd_din, dout, busy, done;
  logic [3:0] cfg_pat, hit_cnt;
  logic [2:0] cfg_len;
  logic [7:0] in_data;
  logic [1:0] dbg_state;

  logic       u2_cfg_we, u2_in_valid, u2_in_ready, u2_sd_din, u2_dout, u2_busy, u2_done;
  logic [3:0] u2_cfg_pat;
  logic [2:0] u2_cfg_len;
  logic [7:0] u2_in_data;
  logic [1:0] u2_hit_cnt, u2_dbg_state;
`ifdef SD_LED_EN
  logic [2:0] led, u2_led;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  m_pat;
  int          m_len;

  always #5 clk = ~clk;

  sd_frame_ctrl #(.W(8), .PMAX(4), .LW(3), .CW(4)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sd_din(sd_din),
    .dout(dout), .busy(busy), .done(done), .hit_cnt(hit_cnt),
`ifdef SD_LED_EN
    .led(led),
`endif
    .dbg_state(dbg_state)
  );

  sd_frame_ctrl #(.W(8), .PMAX(4), .LW(3), .CW(2)) u2 (
    .clk(clk), .reset(reset), .cfg_we(u2_cfg_we), .cfg_pat(u2_cfg_pat), .cfg_len(u2_cfg_len),
    .in_valid(u2_in_valid), .in_ready(u2_in_ready), .in_data(u2_in_data), .sd_din(u2_sd_din),
    .dout(u2_dout), .busy(u2_busy), .done(u2_done), .hit_cnt(u2_hit_cnt),
`ifdef SD_LED_EN
    .led(u2_led),
`endif
    .dbg_state(u2_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit k (0 = first received) completes a match when the last l received bits equal p[l-1:0].
  function automatic logic model_hit(logic [7:0] d, int k, logic [3:0] p, int l);
    if (l == 0 || k + 1 < l) return 1'b0;
    for (int j = 0; j < l; j++)
      if (d[W-1-(k-j)] !== p[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hit_cnt"}, hit_cnt, 0);
    chk({tag, "_sd_din"}, sd_din, 0);
    chk({tag, "_dout"}, dout, 0);
`ifdef SD_LED_EN
    chk({tag, "_led"}, led, 3'b001);
`endif
  endtask

  task automatic write_cfg(input logic [3:0] p, input int l);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pat = p; cfg_len = 3'(l);
    @(negedge clk);
    cfg_we = 1'b0;
    m_pat = p; m_len = (l > 4) ? 4 : l;
  endtask

  // mode 0: plain frame; 1: cfg_we with the accept; 2: cfg_we and in_valid pulsed while busy
  task automatic run_frame(input logic [7:0] d, input int mode, input logic [3:0] np, input int nl);
    int hits;
    logic [31:0] exp_cnt;
    if (mode == 1) begin m_pat = np; m_len = (nl > 4) ? 4 : nl; end
    hits = 0;
    for (int k = 0; k < W; k++) hits += int'(model_hit(d, k, m_pat, m_len));
    exp_q.push_back((hits > 15) ? 32'd15 : 32'(hits));
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = d;
    if (mode == 1) begin cfg_we = 1'b1; cfg_pat = np; cfg_len = 3'(nl); end
    @(negedge clk);
    in_valid = (mode == 2); cfg_we = 1'b0;
    in_data = 8'($urandom_range(0, 255));
    for (int k = 0; k < W; k++) begin
      if (mode == 2 && k == 2) begin cfg_we = 1'b1; cfg_pat = 4'h1; cfg_len = 3'd1; end
      else cfg_we = 1'b0;
      chk($sformatf("sd_din_b%0d", k), sd_din, d[W-1-k]);
      chk($sformatf("dout_b%0d", k), dout, model_hit(d, k, m_pat, m_len));
      chk("shift_busy", busy, 1);
      chk("shift_in_ready", in_ready, 0);
`ifdef SD_LED_EN
      chk("led_shift", led, 3'b010);
`endif
      @(negedge clk);
    end
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("report_done", done, 1);
    chk("report_busy", busy, 1);
`ifdef SD_LED_EN
    chk("led_report", led, 3'b100);
`endif
    exp_cnt = exp_q.pop_front();
    chk("hit_cnt", hit_cnt, exp_cnt);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("hit_cnt_hold", hit_cnt, exp_cnt);
`ifdef SD_LED_EN
    chk("led_idle", led, 3'b001);
`endif
  endtask

  initial begin
    cfg_we = 0; cfg_pat = 0; cfg_len = 0; in_valid = 0; in_data = 0;
    u2_cfg_we = 0; u2_cfg_pat = 0; u2_cfg_len = 0; u2_in_valid = 0; u2_in_data = 0;
    m_pat = 4'h7; m_len = 3;
    reset = 1'b0;
    #1;
    check_reset_values("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_frame(8'hBD, 0, 4'h0, 0);          // default 111 -> 2 hits
    write_cfg(4'h5, 3);
    run_frame(8'hAA, 0, 4'h0, 0);          // 101 -> 3 hits
    write_cfg(4'h7, 3);
    run_frame(8'hFF, 2, 4'h0, 0);          // cfg while busy ignored -> 6
    run_frame(8'h03, 0, 4'h0, 0);
    run_frame(8'hC0, 0, 4'h0, 0);          // no cross-frame match
    run_frame(8'hFF, 1, 4'hF, 7);          // len clamped to 4 -> 5
    write_cfg(4'h1, 0);
    run_frame(8'hFF, 0, 4'h0, 0);          // detector disabled

    // Reset in SHIFT cycle 4 with a nondefault config in force.
    write_cfg(4'h1, 1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_hit_cnt", hit_cnt, 3);
    reset = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    m_pat = 4'h7; m_len = 3;
    for (int i = 0; i < 10; i++) begin
      chk("no_done_after_reset", done, 0);
      @(negedge clk);
    end
    run_frame(8'hBD, 0, 4'h0, 0);          // config back to 111

    for (int i = 0; i < 3; i++)
      run_frame(8'($urandom_range(0, 255)), 1, 4'($urandom_range(0, 15)), $urandom_range(0, 7));

    // Saturation on the CW=2 instance.
    exp_q.push_back(32'd3);
    @(negedge clk);
    u2_cfg_we = 1'b1; u2_cfg_pat = 4'h1; u2_cfg_len = 3'd1;
    u2_in_valid = 1'b1; u2_in_data = 8'hFF;
    @(negedge clk);
    u2_cfg_we = 1'b0; u2_in_valid = 1'b0;
    repeat (W) @(negedge clk);
    chk("u2_done", u2_done, 1);
    chk("u2_hit_cnt_sat", u2_hit_cnt, exp_q.pop_front());

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
